// File: rtl/rr_arbiter_pkg.sv
// rr_arbiter_pkg: shared types and constants for the round-robin arbiter.
// The optional grant timeout is enabled by defining RR_ARB_TIMEOUT_EN.
package rr_arbiter_pkg;

  // Arbiter state encoding: IDLE = 0 (no owner), BUSY = 1 (owner = grant_id).
  typedef enum logic {
    RR_IDLE = 1'b0,
    RR_BUSY = 1'b1
  } rr_state_t;

  // Grant index is always carried zero-extended to this width.
  localparam int GID_W = 8;

endpackage : rr_arbiter_pkg

// File: rtl/rr_arbiter_prio_enc.sv
// prio_enc: most-significant-set-bit search over 2^WIDTH_LOG inputs.
// Purely combinational; the index output is zero-extended to 8 bits.
module prio_enc
  import rr_arbiter_pkg::*;
#(
  parameter int WIDTH_LOG = 2
) (
  input  logic [(1<<WIDTH_LOG)-1:0] i_vec,
  output logic [GID_W-1:0]          o_idx,
  output logic                      o_valid
);

  localparam int N = 1 << WIDTH_LOG;

  // Scan upward so the highest set bit is the last one written.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) begin
        o_idx   = GID_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule : prio_enc

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter for one shared resource, N = 2^WIDTH_LOG
// requesters. Grants are registered and held until the owner drops req.
// Define RR_ARB_TIMEOUT_EN to revoke grants held longer than MAX_HOLD cycles
// and block the offender until it releases its request.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int WIDTH_LOG = 2,
  parameter int MAX_HOLD  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [(1<<WIDTH_LOG)-1:0] i_req,
  output logic [(1<<WIDTH_LOG)-1:0] o_grant,
  output logic                      o_grant_valid,
  output logic [GID_W-1:0]          o_grant_id,
  output logic                      o_timeout
);

  localparam int N = 1 << WIDTH_LOG;

  rr_state_t        r_state;
  logic [N-1:0]     r_grant;
  logic             r_grant_valid;
  logic [GID_W-1:0] r_grant_id;
  logic [GID_W-1:0] r_last;
  logic             r_timeout;

  logic [N-1:0]     w_req_eff;
  logic [N-1:0]     w_low_mask;
  logic [N-1:0]     w_low;
  logic [N-1:0]     w_pe_in;
  logic [GID_W-1:0] w_win;
  logic             w_win_valid;
  logic [N-1:0]     w_onehot;
  logic             w_owner_req;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HOLD_W = ($clog2(MAX_HOLD + 1) > 8) ? $clog2(MAX_HOLD + 1) : 8;

  logic [HOLD_W-1:0] r_hold;
  logic [N-1:0]      r_block;

  assign w_req_eff = i_req & ~r_block;
`else
  logic w_unused_cfg;

  // MAX_HOLD only matters when the timeout is built in.
  assign w_unused_cfg = ^MAX_HOLD;
  assign w_req_eff    = i_req;
`endif

  // Requesters strictly below the last owner get first pick.
  always_comb begin
    w_low_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_low_mask[i] = (i < int'(r_last));
    end
  end

  assign w_low       = w_req_eff & w_low_mask;
  assign w_pe_in     = (|w_low) ? w_low : w_req_eff;
  assign w_owner_req = i_req[r_grant_id[WIDTH_LOG-1:0]];

  prio_enc #(
    .WIDTH_LOG(WIDTH_LOG)
  ) u_prio_enc (
    .i_vec  (w_pe_in),
    .o_idx  (w_win),
    .o_valid(w_win_valid)
  );

  // One-hot decode of the winning index.
  always_comb begin
    w_onehot = '0;
    w_onehot[w_win[WIDTH_LOG-1:0]] = 1'b1;
  end

  // Arbitration state machine with registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= RR_IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_last        <= '0;
      r_timeout     <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      r_hold        <= '0;
      r_block       <= '0;
`endif
    end else begin
      r_timeout <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      // A blocked requester is forgiven once it has let go of req.
      r_block <= r_block & i_req;
`endif
      case (r_state)
        RR_IDLE: begin
          if (w_win_valid) begin
            r_state       <= RR_BUSY;
            r_grant       <= w_onehot;
            r_grant_valid <= 1'b1;
            r_grant_id    <= w_win;
            r_last        <= w_win;
`ifdef RR_ARB_TIMEOUT_EN
            r_hold        <= HOLD_W'(1);
`endif
          end
        end
        RR_BUSY: begin
          if (!w_owner_req) begin
            r_state       <= RR_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
          end
`ifdef RR_ARB_TIMEOUT_EN
          else if (r_hold == HOLD_W'(MAX_HOLD)) begin
            r_state       <= RR_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_timeout     <= 1'b1;
            r_block       <= (r_block & i_req) | r_grant;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
`endif
        end
        default: r_state <= RR_IDLE;
      endcase
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_valid = r_grant_valid;
  assign o_grant_id    = r_grant_id;
  assign o_timeout     = r_timeout;

endmodule : rr_arbiter

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed, table-driven checks of rr_arbiter with N = 4,
// MAX_HOLD = 8, plus hand-written hold/timeout sequences.
module tb_rr_arbiter;

  localparam int WL = 2;
  localparam int N  = 1 << WL;
  localparam int MH = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [7:0]   grant_id;
  logic         timeout;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [7:0]   id;
    string        name;
  } vec_t;

  vec_t vecs[$];

  rr_arbiter #(
    .WIDTH_LOG(WL),
    .MAX_HOLD (MH)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req),
    .o_grant      (grant),
    .o_grant_valid(grant_valid),
    .o_grant_id   (grant_id),
    .o_timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [N-1:0] eg,
                           input logic [7:0] eid, input logic eto);
    check({name, ".grant"}, int'(grant), int'(eg));
    check({name, ".valid"}, int'(grant_valid), int'(eg != '0));
    check({name, ".id"}, int'(grant_id), int'(eid));
    check({name, ".timeout"}, int'(timeout), int'(eto));
  endtask

  // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic [N-1:0] q);
    @(negedge clk);
    rst = r;
    req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [N-1:0] q,
                     input logic [N-1:0] g, input logic [7:0] id, input string nm);
    vec_t v;
    v.rst = r; v.req = q; v.grant = g; v.id = id; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;

    // rst, req, expected grant, expected id
    add(1, 4'b1111, 4'b0000, 0, "rst_a");
    add(1, 4'b1111, 4'b0000, 0, "rst_b");
    add(0, 4'b1111, 4'b1000, 3, "first_id3");
    add(0, 4'b1010, 4'b1000, 3, "hold3_1010");
    add(0, 4'b1011, 4'b1000, 3, "hold3_1011");
    add(0, 4'b0011, 4'b0000, 0, "rel3_dead");
    add(0, 4'b0011, 4'b0010, 1, "grant_id1");
    add(0, 4'b0001, 4'b0000, 0, "rel1_dead");
    add(0, 4'b0001, 4'b0001, 0, "grant_id0");
    add(0, 4'b1000, 4'b0000, 0, "rel0_dead");
    add(0, 4'b1000, 4'b1000, 3, "wrap_id3");
    add(0, 4'b0000, 4'b0000, 0, "rel3_idle");
    add(0, 4'b0001, 4'b0001, 0, "single0");
    add(0, 4'b0000, 4'b0000, 0, "single0_drop");
    add(0, 4'b0001, 4'b0001, 0, "single0_regrant");
    add(0, 4'b0111, 4'b0001, 0, "no_preempt");
    add(0, 4'b0110, 4'b0000, 0, "rel0_dead2");
    add(0, 4'b0110, 4'b0100, 2, "grant_id2");
    add(1, 4'b0110, 4'b0000, 0, "rst_in_busy");
    add(0, 4'b0110, 4'b0100, 2, "post_rst_id2");
    add(0, 4'b1110, 4'b0100, 2, "hold2");

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].req);
      check_out(vecs[k].name, vecs[k].grant, vecs[k].id, 1'b0);
    end

    // Clean restart for the long-hold sequence.
    step(1, 4'b0000);
    check_out("rst_c", 4'b0000, 0, 1'b0);

`ifdef RR_ARB_TIMEOUT_EN
    step(0, 4'b0101);
    check_out("to_grant2", 4'b0100, 2, 1'b0);
    for (int c = 1; c < MH; c++) begin
      step(0, 4'b0101);
      check_out($sformatf("to_hold_%0d", c), 4'b0100, 2, 1'b0);
    end
    step(0, 4'b0101);
    check_out("to_revoke", 4'b0000, 0, 1'b1);
    step(0, 4'b0101);
    check_out("to_next_id0", 4'b0001, 0, 1'b0);
    step(0, 4'b0100);
    check_out("to_rel0", 4'b0000, 0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(0, 4'b0100);
      check_out($sformatf("to_blocked_%0d", c), 4'b0000, 0, 1'b0);
    end
    step(0, 4'b0000);
    check_out("to_req2_low", 4'b0000, 0, 1'b0);
    step(0, 4'b0100);
    check_out("to_regrant2", 4'b0100, 2, 1'b0);
`else
    step(0, 4'b0101);
    check_out("long_grant2", 4'b0100, 2, 1'b0);
    for (int c = 1; c < 20; c++) begin
      step(0, 4'b0101);
      check_out($sformatf("long_hold_%0d", c), 4'b0100, 2, 1'b0);
    end
    step(0, 4'b0001);
    check_out("long_rel2", 4'b0000, 0, 1'b0);
    step(0, 4'b0001);
    check_out("long_next_id0", 4'b0001, 0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_rr_arbiter
